// File: rtl/hcsr04_pkg.sv
// Shared types, default timing constants and the mm-to-echo-cycles conversion
// for the HC-SR04 responder model and the bench checkers that pair with it.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  localparam int CLK_PERIOD_NS = 10;
  localparam int TIMEOUT_CYC   = 3800000;
  localparam int MAX_MM        = 4000;
  localparam int CYC_PER_MM    = 589;
  localparam int TRIG_MIN_CYC  = 1000;
  localparam int BURST_CYC     = 20000;
  localparam int HOLDOFF_CYC   = 1000000;

  // Zero distance is treated like an out-of-range target, as the real sensor would time out.
  function automatic logic mm_out_of_range(input logic [11:0] mm, input int max_mm);
    return (mm == 12'd0) || (32'(mm) > 32'(max_mm));
  endfunction

  function automatic logic [21:0] mm_to_cycles(input logic [11:0] mm, input int cyc_per_mm,
                                               input int max_mm, input int timeout_cyc);
    if (mm_out_of_range(mm, max_mm)) return 22'(timeout_cyc);
    return 22'(mm) * 22'(cyc_per_mm);
  endfunction

endpackage

// File: rtl/hcsr04_echo_model.sv
// HC-SR04 responder emulation: qualifies the trigger pulse, waits out the burst
// delay, then drives an echo whose width encodes the programmed distance.
module hcsr04_echo_model #(
  parameter int TRIG_MIN_CYC = hcsr04_pkg::TRIG_MIN_CYC,
  parameter int BURST_CYC    = hcsr04_pkg::BURST_CYC,
  parameter int CYC_PER_MM   = hcsr04_pkg::CYC_PER_MM,
  parameter int MAX_MM       = hcsr04_pkg::MAX_MM,
  parameter int TIMEOUT_CYC  = hcsr04_pkg::TIMEOUT_CYC,
  parameter int HOLDOFF_CYC  = hcsr04_pkg::HOLDOFF_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [11:0] distance_mm,
  output logic        echo,
  output logic        busy,
  output logic        short_trig,
  output logic        out_of_range
);

  import hcsr04_pkg::*;

  state_t      state;
  logic        trig_q;
  logic [9:0]  wcnt;
  logic [21:0] dcnt;
  logic [21:0] echo_len;

  // One shared down-counter serves burst delay, echo width and holdoff in turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      trig_q       <= 1'b0;
      wcnt         <= '0;
      dcnt         <= '0;
      echo_len     <= '0;
      echo         <= 1'b0;
      busy         <= 1'b0;
      short_trig   <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      trig_q     <= trig;
      short_trig <= 1'b0;
      case (state)
        IDLE: begin
          // Rising edge only, so a trig still high when holdoff ends is not taken.
          if (trig && !trig_q) begin
            wcnt  <= 10'd1;
            state <= TRIG_HI;
          end
        end
        TRIG_HI: begin
          if (trig) begin
            if (wcnt < 10'(TRIG_MIN_CYC)) wcnt <= wcnt + 10'd1;
          end else if (trig_q) begin
            wcnt <= '0;
            if (wcnt >= 10'(TRIG_MIN_CYC)) begin
              echo_len     <= mm_to_cycles(distance_mm, CYC_PER_MM, MAX_MM, TIMEOUT_CYC);
              out_of_range <= mm_out_of_range(distance_mm, MAX_MM);
              busy         <= 1'b1;
              dcnt         <= 22'(BURST_CYC - 1);
              state        <= BURST;
            end else begin
              short_trig <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        BURST: begin
          if (dcnt == '0) begin
            echo  <= 1'b1;
            dcnt  <= echo_len - 22'd1;
            state <= ECHO;
          end else begin
            dcnt <= dcnt - 22'd1;
          end
        end
        ECHO: begin
          if (dcnt == '0) begin
            echo  <= 1'b0;
            dcnt  <= 22'(HOLDOFF_CYC - 1);
            state <= HOLDOFF;
          end else begin
            dcnt <= dcnt - 22'd1;
          end
        end
        HOLDOFF: begin
          if (dcnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dcnt <= dcnt - 22'd1;
          end
        end
        default: begin
          state        <= IDLE;
          wcnt         <= '0;
          dcnt         <= '0;
          echo         <= 1'b0;
          busy         <= 1'b0;
          short_trig   <= 1'b0;
          out_of_range <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hcsr04_echo_model.md
Name: hcsr04_echo_model

Overview:
- Synthesizable responder-side model of the HC-SR04 ultrasonic sensor. It accepts the trigger pulse from the existing sensor controller and returns an echo pulse whose width encodes a programmed distance.
- Used for on-FPGA loopback and hardware-in-the-loop testing of the ranging path without a physical sensor.
- Runs on the 100 MHz system clock (10 ns per cycle).

Parameters:
- TRIG_MIN_CYC, 1000, minimum trig high width accepted as a valid trigger (10 us).
- BURST_CYC, 20000, delay from the qualified trig fall to echo rise (200 us, emulating the 8-cycle 40 kHz burst).
- CYC_PER_MM, 589, echo high cycles per mm of programmed distance.
- MAX_MM, 4000, largest in-range distance in mm.
- TIMEOUT_CYC, 3800000, echo width for out-of-range or zero distance (38 ms).
- HOLDOFF_CYC, 1000000, dead time after echo fall during which triggers are ignored (10 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- trig  in  1  trigger from the sensor controller
- distance_mm  in  12  programmed target distance in mm; sampled when the trigger qualifies
- echo  out  1  emulated echo pulse, registered
- busy  out  1  high from trigger qualification until holdoff ends
- short_trig  out  1  one-cycle pulse when a trig high phase shorter than TRIG_MIN_CYC ends
- out_of_range  out  1  sticky flag for the current measurement: set when a timeout echo is chosen, cleared on the next qualified trigger

Behaviour:
- Reset state while rst is high at a clock edge: echo=0, busy=0, short_trig=0, out_of_range=0, all counters=0, trig_q=0, state=IDLE. rst overrides any state, including mid-echo; echo falls on the reset edge.
- trig_q is trig registered by one cycle. A fall is the cycle where trig_q=1 and trig=0.
- IDLE: when trig=1, move to TRIG_HI and set wcnt=1.
- TRIG_HI: while trig=1, wcnt increments and saturates at TRIG_MIN_CYC.
  - On fall with wcnt>=TRIG_MIN_CYC: latch distance_mm, compute echo length N, set busy=1, load dcnt=BURST_CYC-1, go to BURST.
  - On fall with wcnt<TRIG_MIN_CYC: pulse short_trig for that one cycle and return to IDLE.
- N rule: if distance_mm==0 or distance_mm>MAX_MM, then N=TIMEOUT_CYC and out_of_range=1. Otherwise N=distance_mm*CYC_PER_MM and out_of_range=0. Use a 22-bit product; 4000*589=2,356,000 fits.
- BURST: dcnt decrements. At dcnt==0, set echo=1 on that edge, load dcnt=N-1, go to ECHO. echo therefore rises exactly BURST_CYC cycles after the edge that sampled the fall.
- ECHO: dcnt decrements. At dcnt==0, clear echo, load dcnt=HOLDOFF_CYC-1, go to HOLDOFF. echo is high for exactly N cycles.
- HOLDOFF: dcnt decrements. At 0, clear busy and go to IDLE. If trig is already high on the exit cycle, it is not counted; a fresh rising edge is required.
- trig activity in BURST, ECHO or HOLDOFF is ignored, with no short_trig pulse.
- trig held high indefinitely: stay in TRIG_HI with wcnt saturated; nothing happens until trig falls.
- distance_mm changes after latching have no effect on the measurement in flight.
- States not listed are illegal; they recover to IDLE with outputs at reset values.

Decomposition:
- Package hcsr04_pkg holds:
  - the state enum {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF};
  - the constants CLK_PERIOD_NS=10, TIMEOUT_CYC=3800000, MAX_MM=4000;
  - a function for mm-to-cycles conversion, shared with the controller's bench checker.
- No sub-module; a single FSM with one shared 22-bit down-counter and a 10-bit width counter.

Test Plan:
- distance_mm=100, trig high 1000 cycles -> echo rises 20000 cycles after the fall, high exactly 58900 cycles; out_of_range=0.
- trig high 999 cycles -> short_trig single pulse on the fall cycle; echo stays 0 and busy stays 0.
- distance_mm=0, then distance_mm=4001 -> each gives echo high 3,800,000 cycles with out_of_range=1; distance_mm=4000 gives 2,356,000 cycles with out_of_range=0.
- Extra trig pulses (2000 cycles) during ECHO and HOLDOFF -> ignored; echo width unchanged; a trig 1 cycle after busy falls yields a normal second measurement.
- rst asserted midway through ECHO -> echo=0 and busy=0 on the same edge; the next valid trig produces a full, correct pulse.
- Loopback with the existing HCSR04 controller, distance_mm=500 -> controller reports val=1 and distance=500 ±1 mm.
